barrel_shifter_pipe: RTL
========================

// Module: barrel_shifter_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-mode combinational right shifter.
//  - Supports four modes: SRL, SRA, SLL and ROR.
//  - Register slices sit between groups of mux layers.
//  - Uses a valid/ready handshake with full backpressure.
//  - Sits in the ALU execute path; feeds the ALU result mux.
// PARAMETERS
//  WIDTH      64  data width; power of two, >= 8
//  REG_EVERY  2   mux layers between register slices; 1..log2(WIDTH)
//  derived: SH_W = log2(WIDTH); LATENCY = ceil(SH_W / REG_EVERY) cycles
//  (default LATENCY = 3)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      input operand valid
//  in_ready   out  1      block can accept operand this cycle
//  in_data    in   WIDTH  operand
//  in_shamt   in   SH_W   shift amount; upper bits already masked by the ALU
//  in_op      in   2      00=SRL 01=SRA 10=SLL 11=ROR
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  shifted result
//  out_zero   out  1      [BSH_FLAGS_EN only] out_data == 0
//  out_carry  out  1      [BSH_FLAGS_EN only] last bit shifted out
// BEHAVIOUR
//  - Layer k (k = 0..SH_W-1) shifts by 2^k when shamt[k] = 1. Layers are applied LSB-first.
//  - Fill bits per mode:
//    - SRL: fill with 0.
//    - SRA: fill with data[WIDTH-1].
//    - SLL: fill with 0, low side.
//    - ROR: wrap the vacated bits.
//  - shamt = 0 passes in_data unchanged in every mode.
//  - Each slice holds {valid, partial data, remaining shamt bits, op}.
//    - The final slice drives out_* directly (registered outputs).
//  - Transfer: in on in_valid & in_ready; out on out_valid & out_ready.
//  - Global stall: stall = out_valid & ~out_ready.
//    - On stall, every slice holds its value; in_ready = ~stall (combinational).
//  - Latency is exactly LATENCY cycles from accept to out_valid when there is no stall.
//  - Throughput is 1 result per cycle. Bubbles propagate as valid = 0; empty slices do not stall.
//  - Simultaneous accept and emit on a full pipe is allowed. No loss and no duplication.
//  - Results emerge strictly in input order.
//  - out_data, out_zero and out_carry hold stable while out_valid & ~out_ready.
//  - Reset:
//    - All slice valids go to 0, and out_valid = 0.
//    - out_data, out_zero and out_carry = 0. in_ready = 1 in the cycle after reset.
//  - rst asserted mid-operation discards all in-flight operands. No partial result is emitted.
// CONFIGURATION
//  BSH_FLAGS_EN defined: adds out_zero and out_carry. They are pipelined alongside the data.
//  - out_carry by mode:
//    - SRL, SRA, ROR: in_data[shamt-1].
//    - SLL: in_data[WIDTH-shamt].
//    - shamt = 0 gives 0.
//  - out_zero is computed from the final result and registered with out_data.
//  BSH_FLAGS_EN undefined: both ports and all flag logic are absent. The datapath is identical.
// TESTING  (WIDTH=64, REG_EVERY=2, LATENCY=3)
//  1. Basic modes, consecutive operands with out_ready = 1:
//     - SRL 0x8000_0000_0000_0001 >> 1 -> 0x4000_0000_0000_0000
//     - SRA 0x8000_0000_0000_0000 >> 4 -> 0xF800_0000_0000_0000
//     - SLL 1 << 63 -> 0x8000_0000_0000_0000
//     - ROR 0x1 by 4 -> 0x1000_0000_0000_0000
//     - Each result appears 3 cycles after its accept.
//  2. Boundaries: shamt=0 returns data unchanged in all 4 modes. SRA 0xFFFF_FFFF_FFFF_FFFF by 63 -> all ones.
//     SRL by 63 of 0x8000_0000_0000_0000 -> 0x1.
//  3. Backpressure:
//     - Feed 6 operands back-to-back and hold out_ready = 0 for 5 cycles.
//     - Expect in_ready = 0 while stalled and out_data stable.
//     - Expect all 6 results in order, none dropped or duplicated.
//  4. Bubbles: in_valid toggles 1,0,1. Expect out_valid to show the same 1,0,1 pattern 3 cycles later.
//  5. Reset mid-flight: accept 3 operands, then assert rst for 1 cycle.
//     - Expect out_valid = 0 and out_data = 0.
//     - Expect no stale result afterwards; a new operand emerges 3 cycles after its accept.
//  6. BSH_FLAGS_EN:
//     - SRL 0x3 by 2 -> out_data = 0, out_zero = 1, out_carry = 1.
//     - SLL 0x1 by 0 -> out_carry = 0, out_zero = 0.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined SRL/SRA/SLL/ROR barrel shifter with valid/ready handshake and global stall.
// Optional flag outputs (out_zero, out_carry) are enabled by defining BSH_FLAGS_EN.
module barrel_shifter_pipe #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned REG_EVERY = 2,
    localparam int unsigned SH_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BSH_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    localparam int unsigned NSTG = (SH_W + REG_EVERY - 1) / REG_EVERY;
    // Slices that still need shamt/op for later layers.
    localparam int unsigned NMID = (NSTG > 1) ? NSTG - 1 : 1;

    typedef enum logic [1:0] {
        OpSrl = 2'b00,
        OpSra = 2'b01,
        OpSll = 2'b10,
        OpRor = 2'b11
    } op_e;

    // Applies the mux layers owned by one slice, LSB-first.
    function automatic logic [WIDTH-1:0] shift_layers(input logic [WIDTH-1:0] d,
                                                      input logic [SH_W-1:0]  sh,
                                                      input logic [1:0]       op,
                                                      input int unsigned      stage);
        logic [WIDTH-1:0] r;
        int unsigned      lo;
        int unsigned      hi;
        r  = d;
        lo = stage * REG_EVERY;
        hi = (lo + REG_EVERY > SH_W) ? SH_W : lo + REG_EVERY;
        for (int unsigned k = 0; k < SH_W; k++) begin
            if (k >= lo && k < hi && sh[k]) begin
                case (op_e'(op))
                    OpSrl:   r = r >> (1 << k);
                    OpSra:   r = $signed(r) >>> (1 << k);
                    OpSll:   r = r << (1 << k);
                    default: r = (r >> (1 << k)) | (r << (WIDTH - (1 << k)));
                endcase
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] data_q   [NSTG];
    logic             valid_q  [NSTG];
    logic [SH_W-1:0]  shamt_q  [NMID];
    logic [1:0]       op_q     [NMID];
    logic [WIDTH-1:0] nxt_data [NSTG];
    logic             stall;

    assign stall    = valid_q[NSTG-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        nxt_data    = '{default: '0};
        nxt_data[0] = shift_layers(in_data, in_shamt, in_op, 0);
        for (int unsigned s = 1; s < NSTG; s++) begin
            nxt_data[s] = shift_layers(data_q[s-1], shamt_q[s-1], op_q[s-1], s);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < NSTG; s++) begin
                data_q[s]  <= '0;
                valid_q[s] <= 1'b0;
            end
            for (int unsigned m = 0; m < NMID; m++) begin
                shamt_q[m] <= '0;
                op_q[m]    <= '0;
            end
        end else if (!stall) begin
            // in_ready is 1 whenever we get here, so in_valid alone marks an accept.
            data_q[0]  <= nxt_data[0];
            valid_q[0] <= in_valid;
            shamt_q[0] <= in_shamt;
            op_q[0]    <= in_op;
            for (int unsigned s = 1; s < NSTG; s++) begin
                data_q[s]  <= nxt_data[s];
                valid_q[s] <= valid_q[s-1];
            end
            for (int unsigned m = 1; m < NMID; m++) begin
                shamt_q[m] <= shamt_q[m-1];
                op_q[m]    <= op_q[m-1];
            end
        end
    end

    assign out_valid = valid_q[NSTG-1];
    assign out_data  = data_q[NSTG-1];

`ifdef BSH_FLAGS_EN
    logic [SH_W-1:0] carry_idx;
    logic            carry_in;
    logic            carry_q [NSTG];
    logic            zero_q;

    // The last bit shifted out is known up front, so it rides along with the data.
    always_comb begin
        carry_idx = (op_e'(in_op) == OpSll) ? (SH_W'(0) - in_shamt) : (in_shamt - SH_W'(1));
        carry_in  = (in_shamt != '0) & in_data[carry_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < NSTG; s++) begin
                carry_q[s] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (!stall) begin
            carry_q[0] <= carry_in;
            for (int unsigned s = 1; s < NSTG; s++) begin
                carry_q[s] <= carry_q[s-1];
            end
            zero_q <= ~|nxt_data[NSTG-1];
        end
    end

    assign out_carry = carry_q[NSTG-1];
    assign out_zero  = zero_q;
`endif

endmodule
